// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Bus command encodings, arbiter state type and helpers.
package imem_dmem_arbiter_pkg;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    // Reserved encoding 11 never counts as a data request.
    function automatic logic is_dmem_req(input logic [1:0] cmd);
        return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Processor/memory signal bundle for the IF/MEM memory arbiter.
// master: pipeline + memory side, slave: the arbiter.
interface imem_dmem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        ex_take_branch_out;
    logic [1:0]  dmem_cmd;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] mem2proc_data;

    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic        if_done;
    logic [31:0] if_data;
    logic        dmem_done;
    logic [31:0] dmem_rdata;
    logic        if_stall;
    logic        dmem_stall;

    modport master (
        output if_req,
        output if_addr,
        output ex_take_branch_out,
        output dmem_cmd,
        output dmem_addr,
        output dmem_wdata,
        output mem2proc_data,
        input  proc2mem_command,
        input  proc2mem_addr,
        input  proc2mem_data,
        input  if_done,
        input  if_data,
        input  dmem_done,
        input  dmem_rdata,
        input  if_stall,
        input  dmem_stall
    );

    modport slave (
        input  if_req,
        input  if_addr,
        input  ex_take_branch_out,
        input  dmem_cmd,
        input  dmem_addr,
        input  dmem_wdata,
        input  mem2proc_data,
        output proc2mem_command,
        output proc2mem_addr,
        output proc2mem_data,
        output if_done,
        output if_data,
        output dmem_done,
        output dmem_rdata,
        output if_stall,
        output dmem_stall
    );

endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch and MEM.
// Data accesses win; fetches are squashed by taken branches.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input logic               clk,
    input logic               rst,
    imem_dmem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             kill;
    logic             is_load;

    logic d_req;
    logic d_issue;
    logic i_issue;
    logic rsp;
    logic i_rsp;
    logic d_rsp;

    always_comb begin
        d_req   = is_dmem_req(bus.dmem_cmd);
        d_issue = ~rst && (state == IDLE) && d_req;
        i_issue = ~rst && (state == IDLE) && ~d_req
                  && bus.if_req && ~bus.ex_take_branch_out;
        rsp     = ~rst && (cnt == '0);
        // A branch in the response cycle itself also squashes the fetch.
        i_rsp   = rsp && (state == I_WAIT)
                  && ~kill && ~bus.ex_take_branch_out;
        d_rsp   = rsp && (state == D_WAIT);
    end

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (d_issue) begin
            bus.proc2mem_command = bus.dmem_cmd;
            bus.proc2mem_addr    = word_align(bus.dmem_addr);
            if (bus.dmem_cmd == BUS_STORE) begin
                bus.proc2mem_data = bus.dmem_wdata;
            end
        end else if (i_issue) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = word_align(bus.if_addr);
        end
    end

    assign bus.if_done    = i_rsp;
    assign bus.if_data    = i_rsp ? bus.mem2proc_data : NOOP_INST;
    assign bus.dmem_done  = d_rsp;
    assign bus.dmem_rdata = (d_rsp && is_load) ? bus.mem2proc_data : '0;
    assign bus.if_stall   = ~rst & bus.if_req & ~i_rsp;
    assign bus.dmem_stall = ~rst & d_req & ~d_rsp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            kill    <= 1'b0;
            is_load <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_issue) begin
                        state   <= D_WAIT;
                        cnt     <= CNT_INIT;
                        is_load <= (bus.dmem_cmd == BUS_LOAD);
                    end else if (i_issue) begin
                        state <= I_WAIT;
                        cnt   <= CNT_INIT;
                        kill  <= 1'b0;
                    end
                end
                I_WAIT: begin
                    if (bus.ex_take_branch_out) begin
                        kill <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                D_WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter at latencies 2 and 1.
// Responses are predicted into queues and checked as they appear.
module tb_imem_dmem_arbiter;
    import imem_dmem_arbiter_pkg::*;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   c;
    int   due2     = -1;
    int   due1     = -1;
    logic [31:0] val2;
    logic [31:0] val1;
    exp_t sb2[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    imem_dmem_arbiter_if b2();
    imem_dmem_arbiter_if b1();

    imem_dmem_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) u_dut2 (
        .clk(clk),
        .rst(rst),
        .bus(b2)
    );

    imem_dmem_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == 32'h4) ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) | 32'h1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push2(input bit is_if, input logic [31:0] d, input int at);
        exp_t e;
        e.is_if = is_if; e.data = d; e.cyc = at;
        sb2.push_back(e);
    endtask

    task automatic push1(input bit is_if, input logic [31:0] d, input int at);
        exp_t e;
        e.is_if = is_if; e.data = d; e.cyc = at;
        sb1.push_back(e);
    endtask

    // Sample at the falling edge: feed the memory model, drain scoreboards.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        if (b2.proc2mem_command != BUS_NONE) begin
            due2 = cyc + 2; val2 = memword(b2.proc2mem_addr);
        end
        if (b1.proc2mem_command != BUS_NONE) begin
            due1 = cyc + 1; val1 = memword(b1.proc2mem_addr);
        end
        if (b2.if_done || b2.dmem_done) begin
            if (sb2.size() == 0) begin
                chk("sb2_unexpected_done", {30'd0, b2.if_done, b2.dmem_done}, 32'd0);
            end else begin
                e = sb2.pop_front();
                chk("sb2_kind", {31'd0, b2.if_done}, {31'd0, e.is_if});
                chk("sb2_cycle", cyc, e.cyc);
                chk("sb2_data", e.is_if ? b2.if_data : b2.dmem_rdata, e.data);
            end
        end
        if (b1.if_done || b1.dmem_done) begin
            if (sb1.size() == 0) begin
                chk("sb1_unexpected_done", {30'd0, b1.if_done, b1.dmem_done}, 32'd0);
            end else begin
                e = sb1.pop_front();
                chk("sb1_kind", {31'd0, b1.if_done}, {31'd0, e.is_if});
                chk("sb1_cycle", cyc, e.cyc);
                chk("sb1_data", e.is_if ? b1.if_data : b1.dmem_rdata, e.data);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        b2.mem2proc_data = (cyc == due2) ? val2 : 32'hBADB_AD00;
        b1.mem2proc_data = (cyc == due1) ? val1 : 32'hBADB_AD00;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        rst = 1'b1;
        b2.if_req = 0; b2.if_addr = 0; b2.ex_take_branch_out = 0;
        b2.dmem_cmd = BUS_NONE; b2.dmem_addr = 0; b2.dmem_wdata = 0;
        b2.mem2proc_data = 32'hBADB_AD00;
        b1.if_req = 0; b1.if_addr = 0; b1.ex_take_branch_out = 0;
        b1.dmem_cmd = BUS_NONE; b1.dmem_addr = 0; b1.dmem_wdata = 0;
        b1.mem2proc_data = 32'hBADB_AD00;
        step();
        step();
        rst = 1'b0;

        // reset state
        settle();
        chk("rst_cmd", b2.proc2mem_command, BUS_NONE);
        chk("rst_addr", b2.proc2mem_addr, 0);
        chk("rst_wdata", b2.proc2mem_data, 0);
        chk("rst_if_done", b2.if_done, 0);
        chk("rst_if_data", b2.if_data, NOOP_INST);
        chk("rst_dmem_done", b2.dmem_done, 0);
        chk("rst_dmem_rdata", b2.dmem_rdata, 0);
        chk("rst_stalls", {b2.if_stall, b2.dmem_stall}, 0);
        chk("rst1_if_data", b1.if_data, NOOP_INST);
        adv();

        // 1: single fetch at latency 2
        c = cyc;
        b2.if_req = 1; b2.if_addr = 32'h4;
        push2(1, 32'h0050_0093, c + 2);
        settle();
        chk("t1_cmd", b2.proc2mem_command, BUS_LOAD);
        chk("t1_addr", b2.proc2mem_addr, 32'h4);
        chk("t1_stall0", b2.if_stall, 1);
        adv();
        settle();
        chk("t1_cmd1", b2.proc2mem_command, BUS_NONE);
        chk("t1_if_data1", b2.if_data, NOOP_INST);
        adv();
        settle();
        chk("t1_if_done2", b2.if_done, 1);
        chk("t1_stall2", b2.if_stall, 0);
        chk("t1_no_issue2", b2.proc2mem_command, BUS_NONE);
        adv();
        b2.if_req = 0;

        // 2: simultaneous fetch and load, data first
        c = cyc;
        b2.if_req = 1; b2.if_addr = 32'h40;
        b2.dmem_cmd = BUS_LOAD; b2.dmem_addr = 32'h100;
        push2(0, memword(32'h100), c + 2);
        push2(1, memword(32'h40), c + 5);
        for (int k = 0; k < 6; k++) begin
            if (k == 3) b2.dmem_cmd = BUS_NONE;
            settle();
            chk("t2_if_stall", b2.if_stall, (k <= 4) ? 1 : 0);
            chk("t2_cmd", b2.proc2mem_command,
                (k == 0 || k == 3) ? BUS_LOAD : BUS_NONE);
            if (k == 0) chk("t2_addr_d", b2.proc2mem_addr, 32'h100);
            if (k == 3) chk("t2_addr_i", b2.proc2mem_addr, 32'h40);
            if (k <= 2) chk("t2_dmem_stall", b2.dmem_stall, (k <= 1) ? 1 : 0);
            adv();
        end
        b2.if_req = 0;

        // 3: unaligned store; branch during D_WAIT is ignored
        c = cyc;
        b2.dmem_cmd = BUS_STORE; b2.dmem_addr = 32'h203;
        b2.dmem_wdata = 32'hDEAD_BEEF;
        push2(0, 32'h0, c + 2);
        for (int k = 0; k < 3; k++) begin
            b2.ex_take_branch_out = (k == 1);
            settle();
            chk("t3_cmd", b2.proc2mem_command, (k == 0) ? BUS_STORE : BUS_NONE);
            chk("t3_addr", b2.proc2mem_addr, (k == 0) ? 32'h200 : 32'h0);
            chk("t3_wdata", b2.proc2mem_data, (k == 0) ? 32'hDEAD_BEEF : 32'h0);
            adv();
        end
        b2.dmem_cmd = BUS_NONE; b2.ex_take_branch_out = 0;

        // 4: branch in IDLE blocks issue; branch mid-fetch squashes
        b2.if_req = 1; b2.if_addr = 32'h80; b2.ex_take_branch_out = 1;
        settle();
        chk("t4_idle_branch_cmd", b2.proc2mem_command, BUS_NONE);
        chk("t4_idle_branch_stall", b2.if_stall, 1);
        adv();
        c = cyc;
        b2.ex_take_branch_out = 0;
        settle();
        chk("t4_cmd0", b2.proc2mem_command, BUS_LOAD);
        chk("t4_addr0", b2.proc2mem_addr, 32'h80);
        adv();
        b2.ex_take_branch_out = 1; b2.if_addr = 32'h300;
        push2(1, memword(32'h300), c + 5);
        step();
        b2.ex_take_branch_out = 0;
        settle();
        chk("t4_killed_done", b2.if_done, 0);
        chk("t4_killed_data", b2.if_data, NOOP_INST);
        chk("t4_cmd2", b2.proc2mem_command, BUS_NONE);
        adv();
        settle();
        chk("t4_cmd3", b2.proc2mem_command, BUS_LOAD);
        chk("t4_addr3", b2.proc2mem_addr, 32'h300);
        adv();
        step();
        step();

        // 4b: branch only in the response cycle
        c = cyc;
        b2.if_addr = 32'h84;
        settle();
        chk("t4b_addr0", b2.proc2mem_addr, 32'h84);
        adv();
        step();
        b2.ex_take_branch_out = 1; b2.if_addr = 32'h400;
        push2(1, memword(32'h400), c + 5);
        settle();
        chk("t4b_killed_done", b2.if_done, 0);
        chk("t4b_killed_data", b2.if_data, NOOP_INST);
        adv();
        b2.ex_take_branch_out = 0;
        settle();
        chk("t4b_addr3", b2.proc2mem_addr, 32'h400);
        adv();
        step();
        step();
        b2.if_req = 0;

        // 5: reset during a load
        c = cyc;
        b2.dmem_cmd = BUS_LOAD; b2.dmem_addr = 32'h100;
        settle();
        chk("t5_cmd0", b2.proc2mem_command, BUS_LOAD);
        adv();
        rst = 1'b1;
        settle();
        chk("t5_cmd_in_rst", b2.proc2mem_command, BUS_NONE);
        adv();
        rst = 1'b0; b2.dmem_cmd = BUS_NONE;
        settle();
        chk("t5_no_done", b2.dmem_done, 0);
        chk("t5_rdata", b2.dmem_rdata, 0);
        chk("t5_cmd2", b2.proc2mem_command, BUS_NONE);
        adv();
        settle();
        chk("t5_cmd3", b2.proc2mem_command, BUS_NONE);
        adv();
        c = cyc;
        b2.dmem_cmd = BUS_STORE; b2.dmem_addr = 32'h10; b2.dmem_wdata = 32'h1;
        push2(0, 32'h0, c + 2);
        settle();
        chk("t5_new_issue", b2.proc2mem_command, BUS_STORE);
        adv();
        step();
        step();
        b2.dmem_cmd = BUS_NONE;

        // reserved dmem_cmd 11 never issues and never blocks a fetch
        c = cyc;
        b2.dmem_cmd = 2'b11; b2.if_req = 1; b2.if_addr = 32'h10;
        push2(1, memword(32'h10), c + 2);
        settle();
        chk("rsv_fetch_cmd", b2.proc2mem_command, BUS_LOAD);
        chk("rsv_fetch_addr", b2.proc2mem_addr, 32'h10);
        adv();
        step();
        step();
        b2.if_req = 0;
        settle();
        chk("rsv_alone_cmd", b2.proc2mem_command, BUS_NONE);
        adv();
        b2.dmem_cmd = BUS_NONE;

        // 6: latency 1 back-to-back fetches
        b1.if_req = 1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                b1.if_addr = 32'h20 + 32'(4 * (k / 2));
                push1(1, memword(b1.if_addr), cyc + 1);
            end
            settle();
            chk("t6_cmd", b1.proc2mem_command, (k % 2 == 0) ? BUS_LOAD : BUS_NONE);
            chk("t6_done", b1.if_done, (k % 2 == 1) ? 1 : 0);
            adv();
        end
        b1.if_req = 0;

        step();
        step();
        chk("sb2_left", sb2.size(), 0);
        chk("sb1_left", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
